// File: rtl/uart_pkg.sv
// Shared definitions for blocks that sit in front of the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int BAUD_DIVISOR        = 868;
  localparam int FRAME_BITS          = 11;   // start + 8 data + parity + 1 stop
  localparam int DEFAULT_TIMEOUT_CYC = 12000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the loop, so no path can infer a latch.
  always_comb begin
    any        = 1'b0;
    winner     = '0;
    winner_idx = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among N_REQ byte sources,
// with per-packet frame config and a sticky watchdog on stalled frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   gnt,
  input  logic               cfg_two_stop,
  input  logic               cfg_odd_parity,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_two_stop,
  output logic               tx_odd_parity,
  input  logic               tx_ready,
  input  logic               tx_done,
  output logic               busy,
  output logic               err_timeout,
  input  logic               err_clear
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       state, state_d;
  logic [IDX_W-1:0] owner, rr_ptr, pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_any;
  logic             start_pkt, accept, release_pkt, timeout_hit;
  logic             last_q;
  logic [CNT_W-1:0] wd_cnt;
  logic [7:0]       req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .any        (pick_any),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  always_comb begin
    state_d     = state;
    start_pkt   = 1'b0;
    accept      = 1'b0;
    release_pkt = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          start_pkt = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!req_valid[owner]) begin
          release_pkt = 1'b1;
          state_d     = IDLE;
        end else if (tx_ready) begin
          accept  = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A completing frame takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          release_pkt = last_q;
          state_d     = last_q ? IDLE : ISSUE;
        end else if (wd_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          release_pkt = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= '0;
      gnt           <= '0;
      rr_ptr        <= IDX_W'(N_REQ - 1);
      last_q        <= 1'b0;
      wd_cnt        <= '0;
      tx_two_stop   <= 1'b0;
      tx_odd_parity <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state <= state_d;
      if (start_pkt) begin
        owner         <= pick_idx;
        gnt           <= pick_onehot;
        tx_two_stop   <= cfg_two_stop;
        tx_odd_parity <= cfg_odd_parity;
      end
      if (release_pkt) begin
        gnt    <= '0;
        rr_ptr <= owner;
      end
      if (accept) begin
        last_q <= req_last[owner];
        wd_cnt <= '0;
      end else if (state == WAIT_DONE && wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clear) begin
        err_timeout <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign tx_valid  = (state == ISSUE);
  assign tx_data   = tx_valid ? req_bytes[owner] : 8'h00;
  assign req_ready = accept ? gnt : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed packets against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int N          = 4;
  localparam int TB_TIMEOUT = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, gnt;
  logic [8*N-1:0] req_data;
  logic           cfg_two_stop, cfg_odd_parity;
  logic           tx_valid, tx_two_stop, tx_odd_parity, tx_ready, tx_done;
  logic [7:0]     tx_data;
  logic           busy, err_timeout, err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .gnt(gnt), .cfg_two_stop(cfg_two_stop), .cfg_odd_parity(cfg_odd_parity),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_two_stop(tx_two_stop),
    .tx_odd_parity(tx_odd_parity), .tx_ready(tx_ready), .tx_done(tx_done),
    .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model: who owns the transmitter and what it must show ----------------
  int         m_owner;    // -1 when nobody holds the transmitter
  bit         m_sent;     // owner's current byte is in flight
  bit         m_last, m_err, m_two, m_odd;
  int         m_wait, m_ptr;
  logic [N-1:0] e_gnt, e_ready;
  logic         e_txv;
  logic [7:0]   e_data;

  function automatic int rr_next(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_sent = 0; m_last = 0; m_wait = 0;
    m_ptr = N - 1; m_err = 0; m_two = 0; m_odd = 0;
  endtask

  task automatic m_step();
    bit set_err = 0;
    if (m_owner < 0) begin
      m_owner = rr_next(m_ptr, req_valid);
      if (m_owner >= 0) begin m_sent = 0; m_two = cfg_two_stop; m_odd = cfg_odd_parity; end
    end else if (!m_sent) begin
      if (!req_valid[m_owner]) begin m_ptr = m_owner; m_owner = -1; end
      else if (tx_ready) begin m_sent = 1; m_last = req_last[m_owner]; m_wait = 0; end
    end else if (tx_done) begin
      if (m_last) begin m_ptr = m_owner; m_owner = -1; end
      else m_sent = 0;
    end else if (m_wait == TB_TIMEOUT - 1) begin
      set_err = 1; m_ptr = m_owner; m_owner = -1;
    end else begin
      m_wait++;
    end
    if (set_err) m_err = 1;
    else if (err_clear) m_err = 0;
  endtask

  initial m_reset();

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    e_gnt = '0; e_ready = '0; e_data = 8'h00;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_txv = (m_owner >= 0) && !m_sent;
    if (e_txv) begin
      e_data = req_data[8*m_owner +: 8];
      if (tx_ready && req_valid[m_owner]) e_ready = e_gnt;
    end
    check("gnt", gnt, e_gnt);
    check("busy", busy, m_owner >= 0);
    check("tx_valid", tx_valid, e_txv);
    check("tx_data", tx_data, e_data);
    check("req_ready", req_ready, e_ready);
    check("tx_two_stop", tx_two_stop, m_two);
    check("tx_odd_parity", tx_odd_parity, m_odd);
    check("err_timeout", err_timeout, m_err);
    if (rst_n) m_step();
  end

  // ---------------- directed stimulus ----------------
  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic wait_ready(input int i);
    int n = 0;
    while (!req_ready[i] && n < 60) begin tick(); n++; end
    check("wait_ready", 32'(req_ready[i]), 1);
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 60) begin tick(); n++; end
    check("wait_gnt", 32'(|gnt), 1);
  endtask

  task automatic pulse_done_after(input int cycles);
    repeat (cycles) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  int          got[$];
  int          exp_order [5] = '{0, 1, 2, 3, 0};
  logic [7:0]  pkt [3]       = '{8'h11, 8'h22, 8'h33};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    cfg_two_stop = 0; cfg_odd_parity = 0; tx_ready = 0; tx_done = 0; err_clear = 0;
    repeat (3) tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    tick();

    // Single byte from requester 2; done comes 40 cycles later to stay inside the 50-cycle watchdog.
    req_valid = 4'b0100; req_data[23:16] = 8'hA5; req_last = 4'b0100; tx_ready = 1'b1;
    tick();
    check("t1_gnt", gnt, 4'b0100);
    check("t1_req_ready", req_ready, 4'b0100);
    check("t1_tx_data", tx_data, 8'hA5);
    tick();
    req_valid = '0;
    pulse_done_after(39);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_gnt", gnt, 0);
    // rr_ptr is now 2, so with everyone requesting requester 3 is next.
    req_valid = 4'b1111; req_last = 4'b1111; tx_ready = 1'b0;
    tick();
    check("t1_ptr_next", gnt, 4'b1000);
    req_valid = '0;
    tick();
    check("abandon_gnt", gnt, 0);
    check("abandon_busy", busy, 0);
    do_reset();

    // Round robin with everyone always requesting single-byte packets.
    req_data = 32'hC3C2C1C0; req_valid = 4'b1111; req_last = 4'b1111; tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      got.push_back(onehot_idx(gnt));
      tick();
      pulse_done_after(2);
    end
    for (int k = 0; k < 5; k++) begin
      check("rr_order", got[k], exp_order[k]);
      if (k > 0) check("rr_no_repeat", 32'(got[k] != got[k-1]), 1);
    end

    // Three-byte packet from requester 1 while requester 0 waits; config toggles mid-packet.
    req_valid = 4'b0011; req_last = 4'b0001; req_data = '0;
    req_data[7:0] = 8'h99; req_data[15:8] = pkt[0];
    cfg_odd_parity = 1'b1; cfg_two_stop = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_ready(1);
      check("t3_gnt", gnt, 4'b0010);
      check("t3_tx_data", tx_data, pkt[b]);
      check("t4_odd_held", tx_odd_parity, 1);
      check("t4_two_held", tx_two_stop, 1);
      tick();
      if (b == 0) begin cfg_odd_parity = 1'b0; cfg_two_stop = 1'b0; end
      if (b < 2) begin req_data[15:8] = pkt[b+1]; req_last[1] = (b == 1); end
      else req_valid[1] = 1'b0;
      pulse_done_after(2);
    end
    wait_gnt();
    check("t3_next_owner", gnt, 4'b0001);
    check("t3_next_data", tx_data, 8'h99);
    check("t4_odd_new", tx_odd_parity, 0);
    check("t4_two_new", tx_two_stop, 0);
    tick();
    req_valid = '0;
    pulse_done_after(2);

    // Watchdog: no tx_done at all.
    req_valid = 4'b0001; req_data[7:0] = 8'h5A; req_last = 4'b0001;
    wait_ready(0);
    tick();
    req_valid = '0;
    repeat (49) tick();
    check("t5_err_before", err_timeout, 0);
    check("t5_busy_before", busy, 1);
    tick();
    check("t5_err_set", err_timeout, 1);
    check("t5_gnt_released", gnt, 0);
    check("t5_busy_after", busy, 0);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("t5_err_cleared", err_timeout, 0);
    // tx_done on the very cycle the watchdog would expire.
    req_valid = 4'b0001;
    wait_ready(0);
    tick();
    req_valid = '0;
    repeat (49) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t5_done_wins_err", err_timeout, 0);
    check("t5_done_wins_busy", busy, 0);
    // Set and clear in the same cycle: set wins.
    req_valid = 4'b0001;
    wait_ready(0);
    tick();
    req_valid = '0;
    repeat (49) tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("t5_set_wins", err_timeout, 1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("t5_clear_again", err_timeout, 0);

    // Asynchronous reset while a byte is in flight.
    req_valid = 4'b0100; req_data[23:16] = 8'h3C; req_last = 4'b0100; cfg_odd_parity = 1'b1;
    wait_ready(2);
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("t6_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_gnt_now", gnt, 0);
    check("t6_busy_now", busy, 0);
    check("t6_tx_valid_now", tx_valid, 0);
    check("t6_odd_now", tx_odd_parity, 0);
    req_valid = 4'b1111; req_last = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t6_first_owner", gnt, 4'b0001);
    req_valid = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
